// File: rtl/frame_buf_sched.sv
// Capture frame-buffer scheduler: tracks ownership of NBUF video buffers between the
// camera write path and two register-mapped readers (NIOS = port 0, HPS = port 1).
module frame_buf_sched #(
    parameter int NBUF = 4,
    parameter int IDXW = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            frame_start,
    input  logic            frame_done,
    output logic [IDXW-1:0] wr_buf,
    output logic            wr_en,
    output logic [IDXW-1:0] nr_buf,
    output logic [IDXW-1:0] hr_buf,
    output logic            nr_held,
    output logic            hr_held,
    input  logic [1:0]      nr_address,
    input  logic            nr_bus_enable,
    input  logic            nr_rw,
    input  logic [31:0]     nr_write_data,
    output logic [31:0]     nr_read_data,
    output logic            nr_acknowledge,
    output logic            nr_irq,
    input  logic [1:0]      hr_address,
    input  logic            hr_bus_enable,
    input  logic            hr_rw,
    input  logic [31:0]     hr_write_data,
    output logic [31:0]     hr_read_data,
    output logic            hr_acknowledge,
    output logic            hr_irq
);
    typedef enum logic [2:0] {B_FREE, B_FILLING, B_READY, B_HELD_N, B_HELD_H} buf_state_e;

    localparam int NP = 2;

    buf_state_e      bst_q [NBUF];
    buf_state_e      bst_d [NBUF];

    logic            bus_en   [NP];
    logic [1:0]      addr_in  [NP];
    logic            rw_in    [NP];
    logic            wbit0_in [NP];

    logic            ack_q    [NP];
    logic [1:0]      addr_q   [NP];
    logic            rw_q     [NP];
    logic            wbit0_q  [NP];
    logic            irq_q    [NP];
    logic [31:0]     rdata    [NP];
    logic [15:0]     drops_q;
    logic [15:0]     drops_d;
    logic [IDXW-1:0] wr_buf_q;
    logic            wr_en_q;

    logic            claim_req [NP];
    logic            rel_req   [NP];
    logic            irq_clr   [NP];
    logic            drop_clr  [NP];

    logic            fill_vld, rdy_vld, free_vld;
    logic [IDXW-1:0] rdy_idx, free_idx;
    logic            held_vld [NP];
    logic [IDXW-1:0] held_idx [NP];
    logic            claim_n_ok, claim_h_ok, done_ok;

    logic            unused_wdata;
    assign unused_wdata = ^{nr_write_data[31:1], hr_write_data[31:1]};

    assign bus_en[0]   = nr_bus_enable;
    assign bus_en[1]   = hr_bus_enable;
    assign addr_in[0]  = nr_address;
    assign addr_in[1]  = hr_address;
    assign rw_in[0]    = nr_rw;
    assign rw_in[1]    = hr_rw;
    assign wbit0_in[0] = nr_write_data[0];
    assign wbit0_in[1] = hr_write_data[0];

    // Scan downwards so the lowest-index FREE buffer is the one left in free_idx.
    always_comb begin
        fill_vld = 1'b0;
        rdy_vld  = 1'b0;
        rdy_idx  = '0;
        free_vld = 1'b0;
        free_idx = '0;
        for (int p = 0; p < NP; p++) begin
            held_vld[p] = 1'b0;
            held_idx[p] = '0;
        end
        for (int i = NBUF - 1; i >= 0; i--) begin
            case (bst_q[i])
                B_FREE:    begin free_vld = 1'b1;    free_idx = IDXW'(i);    end
                B_FILLING: fill_vld = 1'b1;
                B_READY:   begin rdy_vld = 1'b1;     rdy_idx = IDXW'(i);     end
                B_HELD_N:  begin held_vld[0] = 1'b1; held_idx[0] = IDXW'(i); end
                B_HELD_H:  begin held_vld[1] = 1'b1; held_idx[1] = IDXW'(i); end
                default:   ;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < NP; gi++) begin : g_port
            assign claim_req[gi] = ack_q[gi] && !rw_q[gi] && (addr_q[gi] == 2'd1);
            assign rel_req[gi]   = ack_q[gi] && !rw_q[gi] && (addr_q[gi] == 2'd2);
            assign irq_clr[gi]   = ack_q[gi] && !rw_q[gi] && (addr_q[gi] == 2'd0) && wbit0_q[gi];
            assign drop_clr[gi]  = ack_q[gi] && !rw_q[gi] && (addr_q[gi] == 2'd3);
        end
    endgenerate

    // Claims see the pre-cycle READY buffer; NIOS has priority when both commit together.
    assign claim_n_ok = claim_req[0] && !held_vld[0] && rdy_vld;
    assign claim_h_ok = claim_req[1] && !held_vld[1] && rdy_vld && !claim_n_ok;
    assign done_ok    = frame_done && fill_vld;

    function automatic buf_state_e buf_next(input buf_state_e cur, input logic pick,
                                            input logic start, input logic done,
                                            input logic cl_n, input logic cl_h,
                                            input logic rel_n, input logic rel_h);
        buf_state_e nxt;
        nxt = cur;
        case (cur)
            B_FREE:    if (start && pick) nxt = B_FILLING;
            B_FILLING: if (done) nxt = B_READY; else if (start) nxt = B_FREE;
            B_READY:   if (cl_n) nxt = B_HELD_N; else if (cl_h) nxt = B_HELD_H;
                       else if (done) nxt = B_FREE;
            B_HELD_N:  if (rel_n) nxt = B_FREE;
            B_HELD_H:  if (rel_h) nxt = B_FREE;
            default:   nxt = B_FREE;
        endcase
        return nxt;
    endfunction

    generate
        for (genvar gi = 0; gi < NBUF; gi++) begin : g_buf
            assign bst_d[gi] = buf_next(bst_q[gi], free_vld && (free_idx == IDXW'(gi)),
                                        frame_start, done_ok, claim_n_ok, claim_h_ok,
                                        rel_req[0], rel_req[1]);
        end
    endgenerate

    always_comb begin
        drops_d = drops_q;
        if (drop_clr[0] || drop_clr[1]) drops_d = '0;
        if (frame_start && !free_vld && (drops_d != 16'hFFFF)) drops_d = drops_d + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NBUF; i++) bst_q[i] <= B_FREE;
            for (int p = 0; p < NP; p++) begin
                ack_q[p]   <= 1'b0;
                addr_q[p]  <= '0;
                rw_q[p]    <= 1'b0;
                wbit0_q[p] <= 1'b0;
                irq_q[p]   <= 1'b0;
            end
            drops_q  <= '0;
            wr_buf_q <= '0;
            wr_en_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NBUF; i++) bst_q[i] <= bst_d[i];
            for (int p = 0; p < NP; p++) begin
                ack_q[p] <= bus_en[p] && !ack_q[p];
                if (bus_en[p] && !ack_q[p]) begin
                    addr_q[p]  <= addr_in[p];
                    rw_q[p]    <= rw_in[p];
                    wbit0_q[p] <= wbit0_in[p];
                end
                if (done_ok) irq_q[p] <= 1'b1;
                else if (irq_clr[p]) irq_q[p] <= 1'b0;
            end
            drops_q <= drops_d;
            if (frame_start) begin
                wr_en_q <= free_vld;
                if (free_vld) wr_buf_q <= free_idx;
            end else if (frame_done) begin
                wr_en_q <= 1'b0;
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NP; p++) begin
            rdata[p] = '0;
            if (ack_q[p] && rw_q[p]) begin
                case (addr_q[p])
                    2'd0: begin
                        rdata[p][IDXW-1:0]  = rdy_idx;
                        rdata[p][8]         = rdy_vld;
                        rdata[p][9]         = irq_q[p];
                        rdata[p][10]        = held_vld[p];
                        rdata[p][16 +: IDXW] = held_idx[p];
                    end
                    2'd1: begin
                        rdata[p][0]         = held_vld[p];
                        rdata[p][8 +: IDXW] = held_idx[p];
                    end
                    2'd3:    rdata[p][15:0] = drops_q;
                    default: ;
                endcase
            end
        end
    end

    assign wr_buf         = wr_buf_q;
    assign wr_en          = wr_en_q;
    assign nr_buf         = held_idx[0];
    assign hr_buf         = held_idx[1];
    assign nr_held        = held_vld[0];
    assign hr_held        = held_vld[1];
    assign nr_read_data   = rdata[0];
    assign hr_read_data   = rdata[1];
    assign nr_acknowledge = ack_q[0];
    assign hr_acknowledge = ack_q[1];
    assign nr_irq         = irq_q[0];
    assign hr_irq         = irq_q[1];
endmodule

// File: tb/tb_frame_buf_sched.sv
// Bench for frame_buf_sched: directed vector table, concurrency sequences, and random
// traffic checked against an ownership-level model (fill / ready / held indices).
module tb_frame_buf_sched;
    localparam int NBUF = 4;
    localparam int IDXW = 3;
    localparam int OP_START = 0, OP_DONE = 1, OP_RD = 2, OP_WR = 3;

    logic            clk = 1'b0, rst = 1'b0, frame_start = 1'b0, frame_done = 1'b0;
    logic [IDXW-1:0] wr_buf, nr_buf, hr_buf;
    logic            wr_en, nr_held, hr_held;
    logic [1:0]      nr_address = '0, hr_address = '0;
    logic            nr_bus_enable = 1'b0, hr_bus_enable = 1'b0, nr_rw = 1'b0, hr_rw = 1'b0;
    logic [31:0]     nr_write_data = '0, hr_write_data = '0, nr_read_data, hr_read_data;
    logic            nr_acknowledge, hr_acknowledge, nr_irq, hr_irq;

    frame_buf_sched #(.NBUF(NBUF), .IDXW(IDXW)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .frame_done(frame_done),
        .wr_buf(wr_buf), .wr_en(wr_en), .nr_buf(nr_buf), .hr_buf(hr_buf),
        .nr_held(nr_held), .hr_held(hr_held),
        .nr_address(nr_address), .nr_bus_enable(nr_bus_enable), .nr_rw(nr_rw),
        .nr_write_data(nr_write_data), .nr_read_data(nr_read_data),
        .nr_acknowledge(nr_acknowledge), .nr_irq(nr_irq),
        .hr_address(hr_address), .hr_bus_enable(hr_bus_enable), .hr_rw(hr_rw),
        .hr_write_data(hr_write_data), .hr_read_data(hr_read_data),
        .hr_acknowledge(hr_acknowledge), .hr_irq(hr_irq)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int          op;
        int          port;
        logic [1:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[$];

    // Reference model: which buffer is filling / ready / held by each reader (-1 = none).
    int   m_fill, m_ready, m_drops;
    int   m_held [2];
    logic m_irq  [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] wrv();
        return {23'd0, wr_en, 5'd0, (wr_en ? wr_buf : 3'd0)};
    endfunction

    function automatic logic [31:0] flags();
        return {28'd0, hr_irq, nr_irq, hr_held, nr_held};
    endfunction

    task automatic add(input int op, input int port, input logic [1:0] a,
                       input logic [31:0] wd, input logic [31:0] exp);
        vec_t v;
        v.op = op; v.port = port; v.addr = a; v.wd = wd; v.exp = exp;
        tbl.push_back(v);
    endtask

    task automatic pulse(input int which);
        if (which == 1) frame_start = 1'b1; else frame_done = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        frame_done  = 1'b0;
    endtask

    // Bus access on one or both ports; 'pulse_sel' raises start(1)/done(2) in the ack cycle.
    task automatic bus_op(input logic [1:0] ports, input logic [1:0] a, input logic rw,
                          input logic [31:0] wd, input int pulse_sel, output logic [31:0] rd);
        logic got;
        got = 1'b0;
        rd  = '0;
        nr_bus_enable = ports[0]; nr_address = a; nr_rw = rw; nr_write_data = wd;
        hr_bus_enable = ports[1]; hr_address = a; hr_rw = rw; hr_write_data = wd;
        @(posedge clk); #1;
        if (pulse_sel == 1) frame_start = 1'b1;
        else if (pulse_sel == 2) frame_done = 1'b1;
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk);
            if ((ports[0] && nr_acknowledge) || (!ports[0] && hr_acknowledge)) begin
                got = 1'b1;
                rd  = ports[0] ? nr_read_data : hr_read_data;
            end
            @(posedge clk); #1;
            frame_start = 1'b0;
            frame_done  = 1'b0;
        end
        nr_bus_enable = 1'b0;
        hr_bus_enable = 1'b0;
        if (!got) check("ack_timeout", 32'(got), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        nr_bus_enable = 1'b0; hr_bus_enable = 1'b0;
        frame_start = 1'b0; frame_done = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        m_fill = -1; m_ready = -1; m_drops = 0;
        m_held[0] = -1; m_held[1] = -1;
        m_irq[0] = 1'b0; m_irq[1] = 1'b0;
    endtask

    task automatic m_start();
        int cand;
        cand = -1;
        for (int i = NBUF - 1; i >= 0; i--)
            if (i != m_fill && i != m_ready && i != m_held[0] && i != m_held[1]) cand = i;
        m_fill = cand;
        if (cand < 0 && m_drops < 65535) m_drops++;
    endtask

    task automatic m_done();
        if (m_fill >= 0) begin
            m_ready  = m_fill;
            m_fill   = -1;
            m_irq[0] = 1'b1;
            m_irq[1] = 1'b1;
        end
    endtask

    task automatic m_write(input int p, input logic [1:0] a, input logic [31:0] wd);
        case (a)
            2'd0: if (wd[0]) m_irq[p] = 1'b0;
            2'd1: if (m_held[p] < 0 && m_ready >= 0) begin m_held[p] = m_ready; m_ready = -1; end
            2'd2: m_held[p] = -1;
            default: m_drops = 0;
        endcase
    endtask

    function automatic logic [31:0] m_read(input int p, input logic [1:0] a);
        logic [31:0] v;
        v = '0;
        case (a)
            2'd0: begin
                if (m_ready >= 0) v[IDXW-1:0] = IDXW'(m_ready);
                v[8]  = (m_ready >= 0);
                v[9]  = m_irq[p];
                v[10] = (m_held[p] >= 0);
                if (m_held[p] >= 0) v[16 +: IDXW] = IDXW'(m_held[p]);
            end
            2'd1: begin
                v[0] = (m_held[p] >= 0);
                if (m_held[p] >= 0) v[8 +: IDXW] = IDXW'(m_held[p]);
            end
            2'd3:    v = 32'(m_drops);
            default: v = '0;
        endcase
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] exp_v;
        int          r, p;
        logic [1:0]  a;
        logic        rw;
        logic [31:0] wd;

        @(posedge clk); #1;
        do_reset();
        check("reset_wr", wrv(), 32'h0);
        check("reset_flags", flags(), 32'h0);
        check("reset_ack", {30'd0, hr_acknowledge, nr_acknowledge}, 32'h0);

        // Directed table from reset (NBUF=4). WR rows expect {hr_irq,nr_irq,hr_held,nr_held}.
        add(OP_START, 0, 0, 0, 32'h100);       add(OP_DONE, 0, 0, 0, 32'h000);
        add(OP_RD, 0, 0, 0, 32'h300);          add(OP_RD, 1, 0, 0, 32'h300);
        add(OP_WR, 0, 1, 32'hDEAD, 32'hD);     add(OP_RD, 0, 1, 0, 32'h1);
        add(OP_RD, 0, 0, 0, 32'h600);          add(OP_START, 0, 0, 0, 32'h101);
        add(OP_DONE, 0, 0, 0, 32'h000);        add(OP_WR, 1, 1, 32'h0, 32'hF);
        add(OP_RD, 1, 1, 0, 32'h101);          add(OP_WR, 0, 0, 32'h1, 32'hB);
        add(OP_RD, 0, 0, 0, 32'h400);          add(OP_START, 0, 0, 0, 32'h102);
        add(OP_DONE, 0, 0, 0, 32'h000);        add(OP_START, 0, 0, 0, 32'h103);
        add(OP_START, 0, 0, 0, 32'h000);       add(OP_RD, 0, 3, 0, 32'h1);
        add(OP_RD, 1, 0, 0, 32'h0001_0702);    add(OP_WR, 1, 3, 32'h5, 32'hF);
        add(OP_RD, 0, 3, 0, 32'h0);            add(OP_WR, 0, 2, 32'h7, 32'hE);
        add(OP_RD, 0, 2, 0, 32'h0);            add(OP_START, 0, 0, 0, 32'h100);
        add(OP_DONE, 0, 0, 0, 32'h000);        add(OP_RD, 0, 0, 0, 32'h300);
        add(OP_WR, 1, 0, 32'h0, 32'hE);        add(OP_RD, 1, 0, 0, 32'h0001_0700);

        foreach (tbl[k]) begin
            $display("txn tbl%0d op=%0d port=%0d addr=%0d", k, tbl[k].op, tbl[k].port, tbl[k].addr);
            case (tbl[k].op)
                OP_START: begin pulse(1); check($sformatf("tbl%0d_start", k), wrv(), tbl[k].exp); end
                OP_DONE:  begin pulse(2); check($sformatf("tbl%0d_done", k), wrv(), tbl[k].exp); end
                OP_RD: begin
                    bus_op(tbl[k].port == 0 ? 2'b01 : 2'b10, tbl[k].addr, 1'b1, 32'h0, 0, rd);
                    check($sformatf("tbl%0d_read", k), rd, tbl[k].exp);
                end
                default: begin
                    bus_op(tbl[k].port == 0 ? 2'b01 : 2'b10, tbl[k].addr, 1'b0, tbl[k].wd, 0, rd);
                    check($sformatf("tbl%0d_write", k), flags(), tbl[k].exp);
                end
            endcase
        end

        // Both ports claim in the same cycle: NIOS takes the READY buffer, HPS gets nothing.
        do_reset();
        pulse(1); pulse(2);
        bus_op(2'b11, 2'd1, 1'b0, 32'h0, 0, rd);
        $display("txn dual_claim");
        check("dual_claim_flags", flags(), 32'hD);
        check("dual_claim_nbuf", 32'(nr_buf), 32'd0);
        bus_op(2'b01, 2'd0, 1'b1, 32'h0, 0, rd);
        check("dual_claim_status", rd, 32'h600);

        // Claim concurrent with frame_done: claimer gets the old READY, new frame becomes READY.
        do_reset();
        pulse(1); pulse(2); pulse(1);
        bus_op(2'b01, 2'd1, 1'b0, 32'h0, 2, rd);
        $display("txn claim_with_done");
        check("claim_done_flags", flags(), 32'hD);
        check("claim_done_nbuf", 32'(nr_buf), 32'd0);
        bus_op(2'b10, 2'd0, 1'b1, 32'h0, 0, rd);
        check("claim_done_status", rd, 32'h301);

        // IRQ clear and set in the same cycle: set wins; old READY recycled.
        pulse(1);
        check("irq_race_start", wrv(), 32'h102);
        bus_op(2'b01, 2'd0, 1'b0, 32'h1, 2, rd);
        $display("txn irq_race");
        check("irq_race_irq", 32'(nr_irq), 32'd1);
        bus_op(2'b01, 2'd0, 1'b1, 32'h0, 0, rd);
        check("irq_race_status", rd, 32'h702);

        // Release concurrent with frame_start: released buffer is not picked this cycle.
        bus_op(2'b01, 2'd2, 1'b0, 32'h0, 1, rd);
        $display("txn release_with_start");
        check("rel_start_wr", wrv(), 32'h101);
        check("rel_start_held", 32'(nr_held), 32'd0);

        // Three unclaimed frames cycle buffers 0,1,0 with no drops.
        do_reset();
        pulse(1); check("cyc_f0", wrv(), 32'h100); pulse(2);
        pulse(1); check("cyc_f1", wrv(), 32'h101); pulse(2);
        pulse(1); check("cyc_f2", wrv(), 32'h100); pulse(2);
        bus_op(2'b01, 2'd3, 1'b1, 32'h0, 0, rd);
        $display("txn three_frames");
        check("cyc_drops", rd, 32'h0);

        // Reset asserted while a frame is being stored.
        pulse(1);
        check("midrst_pre", wrv(), 32'h101);
        rst = 1'b0;
        @(posedge clk); #1;
        $display("txn reset_mid_frame");
        check("midrst_wr", wrv(), 32'h0);
        check("midrst_flags", flags(), 32'h0);
        rst = 1'b1;
        bus_op(2'b01, 2'd0, 1'b1, 32'h0, 0, rd);
        check("midrst_nstatus", rd, 32'h0);
        bus_op(2'b10, 2'd0, 1'b1, 32'h0, 0, rd);
        check("midrst_hstatus", rd, 32'h0);

        // Random sequential traffic against the ownership model.
        do_reset();
        for (int t = 0; t < 250; t++) begin
            r = $urandom_range(0, 9);
            if (r < 2) begin
                pulse(1); m_start();
                $display("txn rnd%0d start", t);
            end else if (r < 4) begin
                pulse(2); m_done();
                $display("txn rnd%0d done", t);
            end else begin
                p  = $urandom_range(0, 1);
                a  = 2'($urandom_range(0, 3));
                rw = 1'($urandom_range(0, 1));
                wd = $urandom;
                $display("txn rnd%0d port=%0d addr=%0d rw=%0d", t, p, a, rw);
                bus_op(p == 0 ? 2'b01 : 2'b10, a, rw, wd, 0, rd);
                if (rw) check($sformatf("rnd%0d_read", t), rd, m_read(p, a));
                else m_write(p, a, wd);
            end
            exp_v = {23'd0, (m_fill >= 0), 5'd0, (m_fill >= 0 ? 3'(m_fill) : 3'd0)};
            check($sformatf("rnd%0d_wr", t), wrv(), exp_v);
            exp_v = {28'd0, m_irq[1], m_irq[0], (m_held[1] >= 0), (m_held[0] >= 0)};
            check($sformatf("rnd%0d_flags", t), flags(), exp_v);
            exp_v = {26'd0, (m_held[1] >= 0 ? 3'(m_held[1]) : 3'd0),
                            (m_held[0] >= 0 ? 3'(m_held[0]) : 3'd0)};
            check($sformatf("rnd%0d_bufs", t), {26'd0, hr_buf, nr_buf}, exp_v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
